mem_port_arbiter: RTL

- Two-requester controller in front of the main memory in the two-level cache hierarchy.
- Typical requesters: port 0 = L2 refill/write-back, port 1 = secondary master.
- Arbitrates round-robin and sequences the memory bus protocol (addr, rw, cs, ce, bidirectional data, RDY).
- Returns read data, a one-cycle ack, and a timeout error to the granted requester.

---
 rtl/mem_port_arbiter.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Two-port round-robin arbiter and bus sequencer in front of main memory.
// One transaction in flight; registered bus, ack/err and read data outputs.
module mem_port_arbiter #(
  parameter int ADDR_W  = 23,
  parameter int DATA_W  = 64,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              r0_req,
  input  logic              r0_rw,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic              r0_ack,
  output logic              r0_err,
  output logic [DATA_W-1:0] r0_rdata,
  input  logic              r1_req,
  input  logic              r1_rw,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_ack,
  output logic              r1_err,
  output logic [DATA_W-1:0] r1_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rw,
  output logic              mem_cs,
  output logic              mem_ce,
  inout  wire  [DATA_W-1:0] mem_data,
  input  logic              mem_rdy
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    SEL,
    ISSUE,
    WAIT,
    DONE
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic              gnt_q;
  logic              gnt_d;
  logic              last_q;
  logic              last_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic [ADDR_W-1:0] addr_d;
  logic              rw_d;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] wdata_d;
  logic              cs_d;
  logic              ce_d;
  logic              ack0_d;
  logic              ack1_d;
  logic              err0_d;
  logic              err1_d;
  logic              cap0;
  logic              cap1;
  logic              pick1;
  logic              fin;
  logic              tmo;

  // Both requesting: favour the port not served last.
  assign pick1 = r1_req & (~r0_req | ~last_q);

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    addr_d  = mem_addr;
    rw_d    = mem_rw;
    wdata_d = wdata_q;
    fin     = 1'b0;
    tmo     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (r0_req | r1_req) begin
          gnt_d   = pick1;
          addr_d  = pick1 ? r1_addr  : r0_addr;
          rw_d    = pick1 ? r1_rw    : r0_rw;
          wdata_d = pick1 ? r1_wdata : r0_wdata;
          state_d = SEL;
        end
      end
      SEL: state_d = ISSUE;
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (mem_rdy) begin
          fin = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          fin = 1'b1;
          tmo = 1'b1;
        end
        if (fin) state_d = DONE;
      end
      DONE: begin
        last_d  = gnt_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cs_d   = 1'b0;
    ce_d   = 1'b0;
    ack0_d = 1'b0;
    ack1_d = 1'b0;
    err0_d = 1'b0;
    err1_d = 1'b0;
    cap0   = 1'b0;
    cap1   = 1'b0;
    unique case (1'b1)
      (state_d == SEL):   cs_d = 1'b1;
      (state_d == ISSUE): begin
        cs_d = 1'b1;
        ce_d = 1'b1;
      end
      (state_d == WAIT):  cs_d = 1'b1;
      default: ;
    endcase
    if (fin) begin
      ack0_d = ~gnt_q;
      ack1_d = gnt_q;
      err0_d = tmo & ~gnt_q;
      err1_d = tmo & gnt_q;
      cap0   = ~tmo & mem_rw & ~gnt_q;
      cap1   = ~tmo & mem_rw & gnt_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      gnt_q    <= 1'b0;
      last_q   <= 1'b1;
      cnt_q    <= '0;
      wdata_q  <= '0;
      mem_addr <= '0;
      mem_rw   <= 1'b1;
      mem_cs   <= 1'b0;
      mem_ce   <= 1'b0;
      r0_ack   <= 1'b0;
      r1_ack   <= 1'b0;
      r0_err   <= 1'b0;
      r1_err   <= 1'b0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      wdata_q  <= wdata_d;
      mem_addr <= addr_d;
      mem_rw   <= rw_d;
      mem_cs   <= cs_d;
      mem_ce   <= ce_d;
      r0_ack   <= ack0_d;
      r1_ack   <= ack1_d;
      r0_err   <= err0_d;
      r1_err   <= err1_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r0_rdata <= '0;
      r1_rdata <= '0;
    end else begin
      if (cap0) r0_rdata <= mem_data;
      if (cap1) r1_rdata <= mem_data;
    end
  end

  // Write data is on the bus for the strobe cycle only.
  assign mem_data = (mem_ce && !mem_rw) ?
    wdata_q : {DATA_W{1'bz}};

endmodule
